wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single writeback/ROB-completion port between NUM_REQ producer pipelines
//  (ALU M/WB, multiplier, load/store). Picks one valid requester per cycle, round-robin.
//  Forwards its completion record (rob_id, result, exception info, pc, type) through one
//  output register to the ROB. Handles ROB backpressure (wb_stall) and pipeline flush.
// PARAMETERS
//  NUM_REQ    3   number of requesting pipelines (>=2)
//  WORD_SIZE  32  width of result/pc/vaddr, `WORD_SIZE in the core
//  ROB_ID_W   7   ROB index width
// PORTS
//  clk            in   1                  core clock
//  reset          in   1                  async, active-low reset
//  flush          in   1                  kill pending writeback (mispredict/exception)
//  req_valid      in   NUM_REQ            requester i has a completion
//  req_ready      out  NUM_REQ            requester i granted this cycle (one-hot or 0)
//  req_type       in   NUM_REQ*2          instruction_type, slice i = [2i+1:2i]
//  req_pc         in   NUM_REQ*WORD_SIZE  pc per requester
//  req_exception  in   NUM_REQ            exception flag per requester
//  req_vaddr      in   NUM_REQ*WORD_SIZE  virtual_addr_exception per requester
//  req_result     in   NUM_REQ*WORD_SIZE  aluResult / load data per requester
//  req_rob_id     in   NUM_REQ*ROB_ID_W   ROB entry per requester
//  wb_stall       in   1                  ROB cannot accept this cycle
//  wb_valid       out  1                  output record valid
//  wb_type/wb_pc/wb_exception/wb_vaddr/wb_result/wb_rob_id  out  widths as above
// BEHAVIOUR
//  - Reset (reset==0, async): wb_valid=0, all wb_* payload=0, prio_ptr=0, counters=0.
//    req_ready is 0 while reset asserted (combinational on state only).
//  - slot_free = !wb_valid || !wb_stall. If !slot_free or flush: req_ready = 0.
//  - Else grant = first i with req_valid[i], scanning prio_ptr, prio_ptr+1, ... mod NUM_REQ.
//    req_ready = one-hot(grant); 0 if no req_valid. req_ready depends combinationally on
//    req_valid; requesters must not make req_valid depend on req_ready.
//  - Transfer on req_valid[i] && req_ready[i]: next edge loads wb_* from slice i, wb_valid=1,
//    prio_ptr = (i+1) mod NUM_REQ (wrap NUM_REQ-1 -> 0). Latency: 1 cycle request->wb_valid.
//  - slot_free && no transfer: wb_valid<=0, payload held, prio_ptr unchanged.
//  - wb_valid && wb_stall: all wb_* held stable; no grant.
//  - flush (any state): next edge wb_valid=0; no grant that cycle; prio_ptr unchanged.
//    flush has priority over wb_stall and over new requests.
//  - Reset mid-operation: in-flight record dropped immediately, no partial output.
//  - At most one record accepted per cycle; a non-granted requester holds its request.
//  - Fairness: a continuously valid requester is granted within NUM_REQ transfers.
// CONFIGURATION
//  WB_ARB_STATS_EN defined: extra outputs
//    stat_conflict  out 32  cycles with >=2 req_valid while slot_free && !flush
//    stat_stall     out 32  cycles with wb_valid && wb_stall
//    both saturating at 32'hFFFF_FFFF, cleared by reset only, registered (visible next cycle).
//  Not defined: ports and counters absent; arbitration behaviour identical.
// TESTING (NUM_REQ=3, WORD_SIZE=32, ROB_ID_W=7, clk period 2)
//  1 Reset: reset=0 with req_valid=3'b111 -> wb_valid=0, req_ready=0, wb_result=0.
//  2 Single req: req_valid=3'b010, rob_id[1]=5, result[1]=42, pc[1]=4 -> req_ready=3'b010;
//    next cycle wb_valid=1, wb_rob_id=5, wb_result=42, wb_pc=4; prio_ptr=2.
//  3 Round-robin: req_valid=3'b111 held 4 cycles from reset -> grants 0,1,2,0; wb_rob_id
//    sequence matches; each requester granted once per 3 cycles.
//  4 Backpressure: wb_valid=1 (rob_id=3), wb_stall=1 for 3 cycles with req_valid=3'b001 ->
//    req_ready=0, wb_rob_id stays 3; after stall drops, next record appears 1 cycle later.
//  5 Flush: transfer rob_id=9 then flush=1 with wb_stall=1 -> next cycle wb_valid=0;
//    req_ready=0 during flush cycle; prio_ptr unchanged.
//  6 Stats (WB_ARB_STATS_EN): 2 cycles req_valid=3'b011 slot free, 1 stalled cycle ->
//    stat_conflict=2, stat_stall=1; without macro bench compiles without these ports.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing the single writeback/ROB-completion port among NUM_REQ pipelines.
// Define WB_ARB_STATS_EN to add saturating conflict/stall counters (stat_conflict, stat_stall).
module wb_port_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int WORD_SIZE = 32,
    parameter int ROB_ID_W  = 7
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*2-1:0]           req_type,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_pc,
    input  logic [NUM_REQ-1:0]             req_exception,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_vaddr,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_result,
    input  logic [NUM_REQ*ROB_ID_W-1:0]    req_rob_id,
    input  logic                           wb_stall,
    output logic                           wb_valid,
    output logic [1:0]                     wb_type,
    output logic [WORD_SIZE-1:0]           wb_pc,
    output logic                           wb_exception,
    output logic [WORD_SIZE-1:0]           wb_vaddr,
    output logic [WORD_SIZE-1:0]           wb_result,
    output logic [ROB_ID_W-1:0]            wb_rob_id,
`ifdef WB_ARB_STATS_EN
    output logic [31:0]                    stat_conflict,
    output logic [31:0]                    stat_stall,
`endif
    output logic [$clog2(NUM_REQ)-1:0]     dbg_prio_ptr
);

    localparam int PTR_W = $clog2(NUM_REQ);

    // Handshake: a record moves from requester i when req_valid[i] && req_ready[i] at a rising
    // edge. req_ready is a combinational function of req_valid and registered state, so a
    // requester must never derive req_valid from req_ready; an ungranted request stays asserted.

    logic [1:0]           type_a   [NUM_REQ];
    logic [WORD_SIZE-1:0] pc_a     [NUM_REQ];
    logic [WORD_SIZE-1:0] vaddr_a  [NUM_REQ];
    logic [WORD_SIZE-1:0] result_a [NUM_REQ];
    logic [ROB_ID_W-1:0]  rob_a    [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign type_a[g]   = req_type[g*2 +: 2];
        assign pc_a[g]     = req_pc[g*WORD_SIZE +: WORD_SIZE];
        assign vaddr_a[g]  = req_vaddr[g*WORD_SIZE +: WORD_SIZE];
        assign result_a[g] = req_result[g*WORD_SIZE +: WORD_SIZE];
        assign rob_a[g]    = req_rob_id[g*ROB_ID_W +: ROB_ID_W];
    end

    logic [PTR_W-1:0]     prio_ptr, prio_d;
    logic                 wb_valid_d;
    logic [1:0]           wb_type_d;
    logic [WORD_SIZE-1:0] wb_pc_d, wb_vaddr_d, wb_result_d;
    logic                 wb_exception_d;
    logic [ROB_ID_W-1:0]  wb_rob_id_d;

    logic                 slot_free;
    logic                 grant_found;
    logic [PTR_W-1:0]     grant_idx;
    logic                 transfer;
    int                   scan_idx;

    // State register: output record plus round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_ptr     <= '0;
            wb_valid     <= 1'b0;
            wb_type      <= '0;
            wb_pc        <= '0;
            wb_exception <= 1'b0;
            wb_vaddr     <= '0;
            wb_result    <= '0;
            wb_rob_id    <= '0;
        end else begin
            prio_ptr     <= prio_d;
            wb_valid     <= wb_valid_d;
            wb_type      <= wb_type_d;
            wb_pc        <= wb_pc_d;
            wb_exception <= wb_exception_d;
            wb_vaddr     <= wb_vaddr_d;
            wb_result    <= wb_result_d;
            wb_rob_id    <= wb_rob_id_d;
        end
    end

    // Output logic: grant scan starting at prio_ptr, wrapping at NUM_REQ.
    always_comb begin
        slot_free   = !wb_valid || !wb_stall;
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        req_ready   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(prio_ptr) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!grant_found && req_valid[PTR_W'(scan_idx)]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(scan_idx);
            end
        end
        if (reset && slot_free && !flush && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign transfer     = |req_ready;
    assign dbg_prio_ptr = prio_ptr;

    // Next-state logic: flush beats stall, stall freezes everything, otherwise load or drain.
    always_comb begin
        prio_d         = prio_ptr;
        wb_valid_d     = wb_valid;
        wb_type_d      = wb_type;
        wb_pc_d        = wb_pc;
        wb_exception_d = wb_exception;
        wb_vaddr_d     = wb_vaddr;
        wb_result_d    = wb_result;
        wb_rob_id_d    = wb_rob_id;
        if (flush) begin
            wb_valid_d = 1'b0;
        end else if (slot_free) begin
            if (transfer) begin
                wb_valid_d     = 1'b1;
                wb_type_d      = type_a[grant_idx];
                wb_pc_d        = pc_a[grant_idx];
                wb_exception_d = req_exception[grant_idx];
                wb_vaddr_d     = vaddr_a[grant_idx];
                wb_result_d    = result_a[grant_idx];
                wb_rob_id_d    = rob_a[grant_idx];
                prio_d         = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            end else begin
                wb_valid_d = 1'b0;
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    int  valid_count;
    logic conflict_cycle;

    always_comb begin
        valid_count = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            valid_count = valid_count + int'(req_valid[k]);
        end
        conflict_cycle = (valid_count >= 2) && slot_free && !flush;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_conflict <= '0;
            stat_stall    <= '0;
        end else begin
            if (conflict_cycle && (stat_conflict != 32'hFFFF_FFFF)) begin
                stat_conflict <= stat_conflict + 32'd1;
            end
            if (wb_valid && wb_stall && (stat_stall != 32'hFFFF_FFFF)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
